sico_play_arbiter: RTL and testbench

Round-robin arbiter that merges N valid/hold playback streams, typically N `SiCoIfPlayer` instances, into one registered output stream. Sits between the DPI stimulus players and the single DUT input port they share. It grants one source per transfer, with optional burst locking, and tags each output word with its source index. Per-source enables allow the bench to mute streams at runtime.

---
 rtl/sico_arb_pkg.sv | 12 +
 rtl/sico_rr_pick.sv | 40 ++++
 rtl/sico_play_arbiter.sv | 132 +++++++++++++
 tb/tb_sico_play_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sico_arb_pkg.sv
// sico_arb_pkg
// Shared types for the playback-stream arbiter.
//   arb_state_t : ARB  - free round-robin search from ptr+1
//                 LOCK - last winner keeps the grant while it still requests
package sico_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sico_rr_pick.sv
// sico_rr_pick
// Combinational rotating priority pick: first set bit of req at or above
// start, wrapping at N-1 back to 0.
// Ports:
//   req   in  N         request vector
//   start in  $clog2(N) first index searched
//   grant out N         one-hot grant, zero when nothing requests
//   found out 1         any request present
//   idx   out $clog2(N) encoded index of the grant (0 when not found)
module sico_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic [N-1:0]         grant,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] j;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            // modulo keeps the wrap correct for non-power-of-2 N
            j = IW'((int'(start) + k) % N);
            if (!found && req[j]) begin
                found    = 1'b1;
                idx      = j;
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sico_play_arbiter.sv
// sico_play_arbiter
// Round-robin merge of N valid/hold playback streams into one registered
// output stream, with optional burst locking and per-source enables.
// Ports:
//   clk_i    in  1          clock
//   rst_i    in  1          asynchronous reset, active high
//   en_i     in  N          per-source enable (disabled sources never win)
//   data_i   in  N*WIDTH    source data, source i at [i*WIDTH +: WIDTH]
//   valid_i  in  N          source valid
//   hold_o   out N          per-source hold, 1 = not accepted this cycle
//   data_o   out WIDTH      merged data (registered)
//   valid_o  out 1          merged valid (registered)
//   src_o    out $clog2(N)  source index of data_o (registered)
//   hold_i   in  1          consumer hold, 1 = keep current word
//
// state | meaning
// ------+-------------------------------------------------------------
// ARB   | round-robin search starting at ptr+1
// LOCK  | lock_src keeps the grant while requesting, burst not yet used up
module sico_play_arbiter
    import sico_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int WIDTH = 32,
    parameter int BURST = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         en_i,
    input  logic [N*WIDTH-1:0]   data_i,
    input  logic [N-1:0]         valid_i,
    output logic [N-1:0]         hold_o,
    output logic [WIDTH-1:0]     data_o,
    output logic                 valid_o,
    output logic [$clog2(N)-1:0] src_o,
    input  logic                 hold_i
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] lock_src;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] cnt_nxt;

    logic [N-1:0]  req;
    logic          can_load;
    logic [IW-1:0] start;
    logic [N-1:0]  pick_grant;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          lock_ok;
    logic [N-1:0]  grant;
    logic [IW-1:0] g_idx;
    logic          load;

    assign req      = valid_i & en_i;
    assign can_load = ~valid_o | ~hold_i;
    assign start    = (ptr == IW'(N - 1)) ? '0 : ptr + 1'b1;

    sico_rr_pick #(.N(N)) u_pick (
        .req   (req),
        .start (start),
        .grant (pick_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The search result doubles as the same-cycle fallback when the locked
    // source stops requesting, so a lock never costs a bubble.
    always_comb begin
        lock_ok = (state == LOCK) && req[lock_src];
        grant   = pick_grant;
        g_idx   = pick_idx;
        if (lock_ok) begin
            grant           = '0;
            grant[lock_src] = 1'b1;
            g_idx           = lock_src;
        end
        load    = (lock_ok | pick_found) & can_load;
        cnt_nxt = lock_ok ? burst_cnt + 1'b1 : CW'(1);
        hold_o  = rst_i ? '1 : ~(grant & {N{can_load}});
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB: begin
                if (load)
                    state_nxt = (cnt_nxt < BURST_C) ? LOCK : ARB;
            end
            LOCK: begin
                if (load)
                    state_nxt = (cnt_nxt < BURST_C) ? LOCK : ARB;
                else if (!req[lock_src])
                    state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ARB;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            data_o    <= '0;
            src_o     <= '0;
            ptr       <= IW'(N - 1);
            lock_src  <= '0;
            burst_cnt <= '0;
        end else if (load) begin
            valid_o   <= 1'b1;
            data_o    <= data_i[int'(g_idx)*WIDTH +: WIDTH];
            src_o     <= g_idx;
            ptr       <= g_idx;
            lock_src  <= g_idx;
            burst_cnt <= cnt_nxt;
        end else if (valid_o && !hold_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sico_play_arbiter.sv
module tb_sico_play_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [N-1:0]   en_i    [2];
    logic [N-1:0]   valid_i [2];
    logic [N-1:0]   hold_o  [2];
    logic [N*W-1:0] data_i  [2];
    logic [W-1:0]   data_o  [2];
    logic           valid_o [2];
    logic [1:0]     src_o   [2];
    logic           hold_i  [2];

    int total = 0;
    int bad   = 0;

    logic [23:0] seq [2][N];
    logic [N-1:0] acc [2];
    logic [33:0] sb [2][$];

    always #5 clk = ~clk;

    // dut index 0: BURST=1, dut index 1: BURST=3
    sico_play_arbiter #(.N(N), .WIDTH(W), .BURST(1)) dut_rr (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i[0]), .data_i(data_i[0]),
        .valid_i(valid_i[0]), .hold_o(hold_o[0]), .data_o(data_o[0]),
        .valid_o(valid_o[0]), .src_o(src_o[0]), .hold_i(hold_i[0])
    );

    sico_play_arbiter #(.N(N), .WIDTH(W), .BURST(3)) dut_bu (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i[1]), .data_i(data_i[1]),
        .valid_i(valid_i[1]), .hold_o(hold_o[1]), .data_o(data_o[1]),
        .valid_o(valid_o[1]), .src_o(src_o[1]), .hold_i(hold_i[1])
    );

    // source word: running sequence number above low byte 0x10+i
    always_comb begin
        data_i[0] = '0;
        data_i[1] = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++)
                data_i[d][i*W +: W] = {seq[d][i], 8'(8'h10 + i)};
    end

    // scoreboard: accepted source words pushed, consumed output words popped
    initial begin
        forever begin
            @(negedge clk);
            acc[0] = '0;
            acc[1] = '0;
            if (!rst_i) begin
                for (int d = 0; d < 2; d++) begin
                    if (valid_o[d] && !hold_i[d]) begin
                        total++;
                        if (sb[d].size() == 0) begin
                            bad++;
                            $display("FAIL sb_dup dut%0d: got src=%0d data=%h, expected no word", d, src_o[d], data_o[d]);
                        end else begin
                            logic [33:0] e;
                            e = sb[d].pop_front();
                            if ({src_o[d], data_o[d]} !== e) begin
                                bad++;
                                $display("FAIL sb_word dut%0d: got %h, expected %h", d, {src_o[d], data_o[d]}, e);
                            end
                        end
                    end
                    for (int i = 0; i < N; i++) begin
                        if (valid_i[d][i] && !hold_o[d][i]) begin
                            acc[d][i] = 1'b1;
                            sb[d].push_back({2'(i), data_i[d][i*W +: W]});
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < N; i++)
                    if (acc[d][i]) seq[d][i] = seq[d][i] + 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        valid_i[0] = '1;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            total += 4;
            if (hold_o[d] !== 4'hF) begin bad++; $display("FAIL rst_hold dut%0d: got %b, expected 1111", d, hold_o[d]); end
            if (valid_o[d] !== 1'b0) begin bad++; $display("FAIL rst_valid dut%0d: got %b, expected 0", d, valid_o[d]); end
            if (data_o[d] !== '0) begin bad++; $display("FAIL rst_data dut%0d: got %h, expected 0", d, data_o[d]); end
            if (src_o[d] !== 2'd0) begin bad++; $display("FAIL rst_src dut%0d: got %0d, expected 0", d, src_o[d]); end
        end
    endtask

    task automatic test_round_robin();
        int exp_src [5] = '{0, 1, 2, 3, 0};
        rst_i = 1'b0;
        #1;
        total++;
        if (valid_o[0] !== 1'b0) begin bad++; $display("FAIL rr_pre_valid: got %b, expected 0", valid_o[0]); end
        for (int k = 0; k < 5; k++) begin
            step();
            total += 2;
            if (valid_o[0] !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %b, expected 1", k, valid_o[0]); end
            if (src_o[0] !== 2'(exp_src[k])) begin bad++; $display("FAIL rr_src[%0d]: got %0d, expected %0d", k, src_o[0], exp_src[k]); end
            if (k == 0) begin
                total++;
                if (data_o[0][7:0] !== 8'h10) begin bad++; $display("FAIL rr_first_data: got %h, expected 10", data_o[0][7:0]); end
            end
        end
        valid_i[0] = '0;
        step();
        total++;
        if (valid_o[0] !== 1'b0) begin bad++; $display("FAIL rr_drain: got %b, expected 0", valid_o[0]); end
    endtask

    task automatic test_burst();
        int exp_src [7] = '{0, 0, 0, 2, 2, 2, 0};
        valid_i[1] = 4'b0101;
        for (int k = 0; k < 7; k++) begin
            step();
            total += 2;
            if (valid_o[1] !== 1'b1) begin bad++; $display("FAIL burst_valid[%0d]: got %b, expected 1", k, valid_o[1]); end
            if (src_o[1] !== 2'(exp_src[k])) begin bad++; $display("FAIL burst_src[%0d]: got %0d, expected %0d", k, src_o[1], exp_src[k]); end
        end
        valid_i[1] = '0;
        step();
    endtask

    task automatic test_early_exit();
        valid_i[1] = 4'b1010;
        step();
        total++;
        if (src_o[1] !== 2'd1) begin bad++; $display("FAIL early_first: got %0d, expected 1", src_o[1]); end
        valid_i[1] = 4'b1000;
        step();
        total += 2;
        if (valid_o[1] !== 1'b1) begin bad++; $display("FAIL early_gap: got valid %b, expected 1", valid_o[1]); end
        if (src_o[1] !== 2'd3) begin bad++; $display("FAIL early_second: got %0d, expected 3", src_o[1]); end
        valid_i[1] = '0;
        step();
        total++;
        if (valid_o[1] !== 1'b0) begin bad++; $display("FAIL early_drain: got %b, expected 0", valid_o[1]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d;
        exp_d = {seq[0][1], 8'h11};
        valid_i[0] = '1;
        step();
        total += 2;
        if (src_o[0] !== 2'd1) begin bad++; $display("FAIL bp_src: got %0d, expected 1", src_o[0]); end
        if (data_o[0] !== exp_d) begin bad++; $display("FAIL bp_data: got %h, expected %h", data_o[0], exp_d); end
        hold_i[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            total += 3;
            if (valid_o[0] !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b, expected 1", k, valid_o[0]); end
            if (data_o[0] !== exp_d) begin bad++; $display("FAIL bp_stable[%0d]: got %h, expected %h", k, data_o[0], exp_d); end
            if (hold_o[0] !== 4'hF) begin bad++; $display("FAIL bp_hold[%0d]: got %b, expected 1111", k, hold_o[0]); end
        end
        hold_i[0] = 1'b0;
        step();
        total += 2;
        if (valid_o[0] !== 1'b1) begin bad++; $display("FAIL bp_resume_valid: got %b, expected 1", valid_o[0]); end
        if (src_o[0] !== 2'd2) begin bad++; $display("FAIL bp_resume_src: got %0d, expected 2", src_o[0]); end
        valid_i[0] = '0;
        step();
    endtask

    task automatic test_enable_mask();
        int exp_src [4] = '{3, 1, 3, 1};
        en_i[0]    = 4'b1010;
        valid_i[0] = '1;
        for (int k = 0; k < 4; k++) begin
            step();
            total += 2;
            if (src_o[0] !== 2'(exp_src[k])) begin bad++; $display("FAIL mask_src[%0d]: got %0d, expected %0d", k, src_o[0], exp_src[k]); end
            if ((hold_o[0] & 4'b0101) !== 4'b0101) begin bad++; $display("FAIL mask_hold[%0d]: got %b, expected x1x1", k, hold_o[0]); end
        end
        valid_i[0] = '0;
        step();
        en_i[0] = '1;
    endtask

    task automatic test_async_reset();
        valid_i[0] = '1;
        step();
        step();
        total++;
        if (valid_o[0] !== 1'b1) begin bad++; $display("FAIL ar_pre_valid: got %b, expected 1", valid_o[0]); end
        #2;
        rst_i = 1'b1;
        #1;
        sb[0].delete();
        sb[1].delete();
        total += 3;
        if (valid_o[0] !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b, expected 0", valid_o[0]); end
        if (hold_o[0] !== 4'hF) begin bad++; $display("FAIL ar_hold: got %b, expected 1111", hold_o[0]); end
        if (src_o[0] !== 2'd0) begin bad++; $display("FAIL ar_src: got %0d, expected 0", src_o[0]); end
        step();
        total++;
        if (hold_o[0] !== 4'hF) begin bad++; $display("FAIL ar_hold_in_rst: got %b, expected 1111", hold_o[0]); end
        rst_i = 1'b0;
        step();
        total += 2;
        if (valid_o[0] !== 1'b1) begin bad++; $display("FAIL ar_post_valid: got %b, expected 1", valid_o[0]); end
        if (src_o[0] !== 2'd0) begin bad++; $display("FAIL ar_post_src: got %0d, expected 0", src_o[0]); end
        valid_i[0] = '0;
        step();
    endtask

    task automatic test_drain();
        valid_i[0] = '0;
        valid_i[1] = '0;
        hold_i[0]  = 1'b0;
        hold_i[1]  = 1'b0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (sb[d].size() != 0) begin bad++; $display("FAIL drain_lost dut%0d: got %0d pending, expected 0", d, sb[d].size()); end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        for (int d = 0; d < 2; d++) begin
            en_i[d]    = '1;
            valid_i[d] = '0;
            hold_i[d]  = 1'b0;
            acc[d]     = '0;
            for (int i = 0; i < N; i++) seq[d][i] = '0;
        end
        test_reset();
        test_round_robin();
        test_burst();
        test_early_exit();
        test_backpressure();
        test_enable_mask();
        test_async_reset();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
